// File: rtl/tx_packet_sequencer_if.sv
// rtl/tx_packet_sequencer_if.sv - command, FIFO and byte-side signals of the TX packet sequencer
interface tx_packet_sequencer_if #(
    parameter int CNT_W = 7
);
    logic [2:0]       tx_packet;
    logic             tx_start;
    logic [CNT_W-1:0] buffer_occupancy;
    logic [7:0]       tx_data;
    logic             get_tx_data;
    logic [7:0]       tx_byte;
    logic             tx_byte_valid;
    logic             byte_ready;
    logic             send_eop;
    logic             eop_done;
    logic             tx_busy;
    logic             tx_done;
    logic             tx_error;

    modport master (
        input  tx_packet, tx_start, buffer_occupancy, tx_data, byte_ready, eop_done,
        output get_tx_data, tx_byte, tx_byte_valid, send_eop, tx_busy, tx_done, tx_error
    );

    modport slave (
        output tx_packet, tx_start, buffer_occupancy, tx_data, byte_ready, eop_done,
        input  get_tx_data, tx_byte, tx_byte_valid, send_eop, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/tx_packet_sequencer.sv
// rtl/tx_packet_sequencer.sv - USB TX byte-level packet sequencer (SYNC, PID, payload, CRC16, EOP)
module tx_packet_sequencer #(
    parameter int MAX_PAYLOAD = 64,
    parameter int CNT_W       = 7
) (
    input logic                   clk,
    input logic                   n_rst,
    tx_packet_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, SYNC, PID, FETCH, DATA, CRC_LO, CRC_HI, EOP, DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAYLOAD);

    state_t           state;
    state_t           state_next;
    logic [2:0]       ptype;
    logic [CNT_W-1:0] remaining;
    logic [15:0]      crc;
    logic [7:0]       tx_byte_r;
    logic             tx_error_r;

    logic cmd_is_data;
    logic cmd_is_hs;
    logic start_ok;
    logic start_bad;
    logic pkt_is_data;
    logic byte_state;
    logic accept;

    // Reflected CRC16 (0x8005 -> 0xA001) over one byte, LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] pid_byte(input logic [2:0] t);
        case (t)
            3'b001:  return 8'hC3;
            3'b010:  return 8'h4B;
            3'b011:  return 8'hD2;
            3'b100:  return 8'h5A;
            3'b101:  return 8'h1E;
            default: return 8'h00;
        endcase
    endfunction

    assign cmd_is_data = (bus.tx_packet == 3'b001) || (bus.tx_packet == 3'b010);
    assign cmd_is_hs   = (bus.tx_packet == 3'b011) || (bus.tx_packet == 3'b100) ||
                         (bus.tx_packet == 3'b101);
    assign start_ok    = bus.tx_start && (cmd_is_hs ||
                         (cmd_is_data && (bus.buffer_occupancy <= MAX_CNT)));
    assign start_bad   = bus.tx_start && !start_ok;
    assign pkt_is_data = (ptype == 3'b001) || (ptype == 3'b010);
    assign byte_state  = (state == SYNC) || (state == PID) || (state == DATA) ||
                         (state == CRC_LO) || (state == CRC_HI);
    assign accept      = byte_state && bus.byte_ready;

    assign bus.tx_byte       = tx_byte_r;
    assign bus.tx_byte_valid = byte_state;
    assign bus.get_tx_data   = (state == FETCH);
    assign bus.send_eop      = (state == EOP);
    assign bus.tx_busy       = (state != IDLE);
    assign bus.tx_done       = (state == DONE);
    assign bus.tx_error      = tx_error_r;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: byte states advance only on an accepted byte
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start_ok) state_next = SYNC;
            SYNC:   if (accept) state_next = PID;
            PID: begin
                if (accept) begin
                    if (!pkt_is_data)          state_next = EOP;
                    else if (remaining != '0)  state_next = FETCH;
                    else                       state_next = CRC_LO;
                end
            end
            FETCH:  state_next = DATA;
            DATA:   if (accept) state_next = (remaining != '0) ? FETCH : CRC_LO;
            CRC_LO: if (accept) state_next = CRC_HI;
            CRC_HI: if (accept) state_next = EOP;
            EOP:    if (bus.eop_done) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: next byte is loaded on the accepting edge so tx_byte never changes while waiting
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptype      <= 3'b000;
            remaining  <= '0;
            crc        <= 16'hFFFF;
            tx_byte_r  <= 8'h00;
            tx_error_r <= 1'b0;
        end else begin
            tx_error_r <= (state == IDLE) && start_bad;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        ptype     <= bus.tx_packet;
                        remaining <= cmd_is_data ? bus.buffer_occupancy : '0;
                        crc       <= 16'hFFFF;
                        tx_byte_r <= 8'h80;
                    end
                end
                SYNC:   if (accept) tx_byte_r <= pid_byte(ptype);
                PID:    if (accept && pkt_is_data && remaining == '0) tx_byte_r <= ~crc[7:0];
                FETCH: begin
                    tx_byte_r <= bus.tx_data;
                    remaining <= remaining - 1'b1;
                    crc       <= crc16_byte(crc, bus.tx_data);
                end
                DATA:   if (accept && remaining == '0) tx_byte_r <= ~crc[7:0];
                CRC_LO: if (accept) tx_byte_r <= ~crc[15:8];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_packet_sequencer.sv
// tb/tb_tx_packet_sequencer.sv - table-driven self-checking bench for tx_packet_sequencer
module tb_tx_packet_sequencer;
    typedef struct packed {
        logic [2:0]       pkt;
        logic [6:0]       occ;
        logic [7:0]       base;
        logic             err;
        logic             bp;
        logic [4:0]       n_exp;
        logic [0:12][7:0] exp;
    } vec_t;

    logic clk;
    logic n_rst;
    int   n_chk;
    int   n_fail;
    int   pop_cnt;
    int   pop_base;
    logic [7:0] fifo_base;
    vec_t vecs[$];

    tx_packet_sequencer_if #(.CNT_W(7)) bus ();

    tx_packet_sequencer #(.MAX_PAYLOAD(64), .CNT_W(7)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: head byte is base + number of pops in this packet
    always @(posedge clk) begin
        if (bus.get_tx_data) pop_cnt <= pop_cnt + 1;
    end
    assign bus.tx_data = fifo_base + 8'(pop_cnt - pop_base);

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bit-serial USB CRC16 over n consecutive bytes starting at base
    function automatic logic [15:0] crc_model(input logic [7:0] base, input int n);
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            d = base + 8'(k);
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    function automatic vec_t mk(input logic [2:0] p, input logic [6:0] o, input logic [7:0] b,
                                input logic e, input logic bp, input logic [4:0] n,
                                input logic [103:0] bytes);
        return {p, o, b, e, bp, n, bytes};
    endfunction

    task automatic start_cmd(input logic [2:0] p, input logic [6:0] o);
        @(negedge clk);
        bus.tx_packet        = p;
        bus.buffer_occupancy = o;
        bus.tx_start         = 1'b1;
        @(negedge clk);
        bus.tx_start         = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx_byte"}, bus.tx_byte, 8'h00);
        chk({tag, "_valid"}, bus.tx_byte_valid, 1'b0);
        chk({tag, "_get"}, bus.get_tx_data, 1'b0);
        chk({tag, "_send_eop"}, bus.send_eop, 1'b0);
        chk({tag, "_busy"}, bus.tx_busy, 1'b0);
        chk({tag, "_done"}, bus.tx_done, 1'b0);
        chk({tag, "_error"}, bus.tx_error, 1'b0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] got_b [0:12];
        int         got;
        int         stall;
        int         eop_cyc;
        bit         prev_stall;
        bit         done_seen;
        bit         ready;
        logic [7:0] prev_byte;
        int         exp_pops;
        pop_base  = pop_cnt;
        fifo_base = v.base;
        start_cmd(v.pkt, v.occ);
        if (v.err) begin
            chk($sformatf("v%0d_error_pulse", idx), bus.tx_error, 1'b1);
            chk($sformatf("v%0d_error_busy", idx), bus.tx_busy, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_error_clear", idx), bus.tx_error, 1'b0);
            chk($sformatf("v%0d_error_idle", idx), bus.tx_busy, 1'b0);
            return;
        end
        chk($sformatf("v%0d_no_error", idx), bus.tx_error, 1'b0);
        got = 0; stall = 0; eop_cyc = 0; prev_stall = 0; done_seen = 0; prev_byte = 8'h00;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            if (prev_stall) begin
                chk($sformatf("v%0d_stall_valid", idx), bus.tx_byte_valid, 1'b1);
                chk($sformatf("v%0d_stall_byte", idx), bus.tx_byte, prev_byte);
            end
            if (bus.send_eop) begin
                eop_cyc++;
                bus.eop_done = (eop_cyc == 3);
            end else begin
                bus.eop_done = 1'b0;
            end
            if (bus.tx_done) done_seen = 1;
            ready = 1'b1;
            if (v.bp && bus.tx_byte_valid) begin
                if (!prev_stall) stall = $urandom_range(0, 5);
                ready = (stall == 0);
                if (stall > 0) stall--;
            end
            bus.byte_ready = ready;
            if (bus.tx_byte_valid && ready) begin
                if (got < 13) got_b[got] = bus.tx_byte;
                got++;
            end
            prev_stall = bus.tx_byte_valid && !ready;
            prev_byte  = bus.tx_byte;
            @(negedge clk);
        end
        bus.eop_done   = 1'b0;
        bus.byte_ready = 1'b1;
        chk($sformatf("v%0d_done_seen", idx), done_seen, 1'b1);
        chk($sformatf("v%0d_eop_cycles", idx), eop_cyc, 3);
        chk($sformatf("v%0d_byte_count", idx), got, v.n_exp);
        for (int j = 0; j < int'(v.n_exp) && j < got && j < 13; j++)
            chk($sformatf("v%0d_byte%0d", idx, j), got_b[j], v.exp[j]);
        exp_pops = (v.pkt == 3'b001 || v.pkt == 3'b010) ? int'(v.occ) : 0;
        chk($sformatf("v%0d_pops", idx), pop_cnt - pop_base, exp_pops);
        chk($sformatf("v%0d_done_once", idx), bus.tx_done, 1'b0);
        chk($sformatf("v%0d_idle_after", idx), bus.tx_busy, 1'b0);
    endtask

    initial begin
        logic [15:0] c4;
        bit          found;
        n_chk = 0; n_fail = 0; pop_base = 0; fifo_base = 8'h00;
        n_rst = 1'b0;
        bus.tx_packet = 3'b000; bus.tx_start = 1'b0; bus.buffer_occupancy = '0;
        bus.byte_ready = 1'b1; bus.eop_done = 1'b0;

        c4 = crc_model(8'h00, 4);
        vecs.push_back(mk(3'b011, 7'd5, 8'h00, 0, 0, 5'd2, {8'h80, 8'hD2, {11{8'h00}}}));
        vecs.push_back(mk(3'b001, 7'd0, 8'h00, 0, 0, 5'd4, {8'h80, 8'hC3, 8'h00, 8'h00, {9{8'h00}}}));
        vecs.push_back(mk(3'b010, 7'd9, 8'h31, 0, 0, 5'd13,
                          {8'h80, 8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                           8'h38, 8'h39, 8'hC8, 8'hB4}));
        vecs.push_back(mk(3'b100, 7'd0, 8'h00, 0, 0, 5'd2, {8'h80, 8'h5A, {11{8'h00}}}));
        vecs.push_back(mk(3'b101, 7'd127, 8'h00, 0, 0, 5'd2, {8'h80, 8'h1E, {11{8'h00}}}));
        vecs.push_back(mk(3'b110, 7'd0, 8'h00, 1, 0, 5'd0, '0));
        vecs.push_back(mk(3'b001, 7'd65, 8'h00, 1, 0, 5'd0, '0));
        vecs.push_back(mk(3'b000, 7'd1, 8'h00, 1, 0, 5'd0, '0));
        vecs.push_back(mk(3'b111, 7'd1, 8'h00, 1, 0, 5'd0, '0));
        vecs.push_back(mk(3'b001, 7'd4, 8'h00, 0, 1, 5'd8,
                          {8'h80, 8'hC3, 8'h00, 8'h01, 8'h02, 8'h03, c4[7:0], c4[15:8], {5{8'h00}}}));
        vecs.push_back(mk(3'b010, 7'd9, 8'h31, 0, 1, 5'd13,
                          {8'h80, 8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                           8'h38, 8'h39, 8'hC8, 8'hB4}));

        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // tx_start (with an invalid type) during PID must be ignored
        start_cmd(3'b011, 7'd0);
        bus.byte_ready = 1'b1;
        @(negedge clk);
        chk("pidstart_pid_byte", bus.tx_byte, 8'hD2);
        bus.tx_start = 1'b1; bus.tx_packet = 3'b110; bus.byte_ready = 1'b0;
        @(negedge clk);
        bus.tx_start = 1'b0;
        chk("pidstart_no_error", bus.tx_error, 1'b0);
        chk("pidstart_hold_byte", bus.tx_byte, 8'hD2);
        chk("pidstart_hold_valid", bus.tx_byte_valid, 1'b1);
        bus.byte_ready = 1'b1;
        @(negedge clk);
        chk("pidstart_send_eop", bus.send_eop, 1'b1);
        bus.eop_done = 1'b1;
        @(negedge clk);
        bus.eop_done = 1'b0;
        chk("pidstart_done", bus.tx_done, 1'b1);
        @(negedge clk);
        chk("pidstart_idle", bus.tx_busy, 1'b0);

        // Asynchronous reset in the middle of the payload
        pop_base = pop_cnt; fifo_base = 8'hA0;
        start_cmd(3'b010, 7'd4);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if ((pop_cnt - pop_base) == 2 && bus.tx_byte_valid) found = 1;
            else @(negedge clk);
        end
        chk("rst_reached_data", found, 1'b1);
        chk("rst_data_byte", bus.tx_byte, 8'hA1);
        #2 n_rst = 1'b0;
        #1 chk_outputs_zero("midrst");
        @(negedge clk);
        n_rst = 1'b1;
        run_vec(99, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_packet_sequencer.md
Name: tx_packet_sequencer

Overview:
- Transmit-side counterpart of the USB RX data buffer. Assembles outgoing USB packets at byte level for the TX bit shifter/encoder.
- On a start command it emits, in order: SYNC, PID, and (data packets only) payload bytes pulled from the TX FIFO plus CRC16. It then requests EOP.
- Sits between the endpoint control/protocol FSM (command side) and the TX shift/NRZI/bit-stuff stage (byte side).

Parameters:
MAX_PAYLOAD, 64, largest accepted payload byte count; occupancy above this is an error.
CNT_W, 7, width of byte counter and buffer_occupancy; must satisfy 2^CNT_W > MAX_PAYLOAD.

Ports:
clk  input  1  clock
n_rst  input  1  asynchronous active-low reset
tx_packet  input  3  packet type: 001 DATA0, 010 DATA1, 011 ACK, 100 NAK, 101 STALL; 000/110/111 invalid
tx_start  input  1  one-cycle start strobe; tx_packet is sampled in the same cycle
buffer_occupancy  input  CNT_W  bytes available in TX FIFO; sampled at tx_start
tx_data  input  8  FIFO head byte; valid whenever occupancy > 0
get_tx_data  output  1  one-cycle FIFO pop
tx_byte  output  8  byte presented to the shifter
tx_byte_valid  output  1  tx_byte valid
byte_ready  input  1  shifter accepts tx_byte when valid and ready are both high
send_eop  output  1  request EOP; held until eop_done
eop_done  input  1  shifter finished EOP
tx_busy  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse when the packet is complete
tx_error  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset: n_rst is asynchronous, active-low; clock is clk. On reset, state is IDLE and all outputs are 0, including tx_byte = 0x00. Reset mid-packet aborts immediately; the FIFO is not rewound.
- States:
  - IDLE, SYNC, PID: SYNC and PID are byte-send states.
  - FETCH: get_tx_data = 1; tx_byte <= tx_data; remaining decrements; CRC updates with tx_data.
  - DATA: byte-send state.
  - CRC_LO, CRC_HI: byte-send states.
  - EOP, DONE.
- Byte-send states:
  - tx_byte_valid = 1, and tx_byte holds stable.
  - The state advances on the edge where tx_byte_valid & byte_ready.
  - The next byte is registered at that same edge, except after FETCH.
- IDLE transitions on tx_start:
  - Valid type with occupancy ≤ MAX_PAYLOAD: latch type and count; load tx_byte = 0x80; CRC = 0xFFFF; go to SYNC.
  - Invalid type, or data type with occupancy > MAX_PAYLOAD: pulse tx_error the next cycle; stay IDLE.
  - For handshake types, occupancy is ignored.
- SYNC -> PID: PID byte is DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- PID transitions:
  - Handshake type -> EOP.
  - Data type with count > 0 -> FETCH.
  - Data type with count = 0 -> CRC_LO.
- FETCH lasts exactly one cycle, then goes to DATA. This gives one bubble cycle (valid = 0) between payload bytes.
- DATA transitions: remaining > 0 -> FETCH; remaining = 0 -> CRC_LO.
- CRC16:
  - Polynomial 0x8005, reflected (shift right, XOR 0xA001), LSB-first.
  - Init 0xFFFF; updated over payload bytes only.
  - Transmitted value is ~crc: CRC_LO sends bits [7:0], then CRC_HI sends bits [15:8].
- CRC_HI -> EOP.
- EOP: send_eop = 1 until eop_done is sampled high, then go to DONE.
- DONE: tx_done = 1 for one cycle, then go to IDLE.
- tx_start while tx_busy is ignored: no error, no effect.
- byte_ready while tx_byte_valid = 0 is ignored.
- eop_done outside EOP is ignored.
- Exactly N get_tx_data pulses are issued per data packet of N bytes; none for handshake packets.

Test Plan:
- ACK: tx_start with tx_packet = 011, byte_ready tied 1 → bytes 0x80, 0xD2; send_eop; eop_done → tx_done pulse; zero get_tx_data pulses.
- Zero-length DATA0: occupancy = 0 → bytes 0x80, 0xC3, 0x00, 0x00; then EOP, then tx_done.
- DATA1 with 9 bytes 0x31..0x39 ("123456789") → bytes 0x80, 0x4B, 0x31..0x39, 0xC8, 0xB4; exactly 9 get_tx_data pulses.
- Backpressure: byte_ready randomly low for 0–5 cycles during the 4-byte payload 00 01 02 03 → tx_byte stable while valid & !ready; no byte dropped or duplicated; CRC matches a software model.
- Errors: tx_packet = 110 → tx_error pulse, tx_busy stays 0. DATA0 with occupancy = 65 → tx_error pulse. tx_start asserted during PID → ignored, packet completes normally.
- Reset: n_rst asserted during DATA → all outputs 0 immediately; after release, a new ACK command transmits correctly.
